// File: rtl/imem_loader_responder.sv
// imem_loader_responder
//   Instruction memory shared by the CPU fetch port and a byte-stream program loader.
//   Fetches return mem[fetch_addr] one cycle later, but only while running.
//   Loads pack 8-bit beats, MSB first, into 32-bit words and write them sequentially
//   from word 0. The CPU is held during a load.
//   Optional feature macro: IMEM_CHECKSUM_EN. When it is defined, ld_checksum carries a
//   16-bit wrapping byte sum of the current load. When it is not defined, ld_checksum
//   is 16'h0000 and no adder is built.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no program yet; CPU held, fetch output zeroed
//   LOAD  | accepting loader beats; CPU held, fetch output zeroed
//   RUN   | serving fetches with 1-cycle latency; CPU released
module imem_loader_responder #(
  parameter int ADDR_W   = 8,
  parameter int BOOT_RUN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic [ADDR_W:0]   ld_word_count,
  output logic              ld_error,
  output logic [15:0]       ld_checksum
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (BOOT_RUN != 0) ? S_RUN : S_IDLE;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word_buf;
  logic              r_error;
  logic [31:0]       r_instr;
  logic              r_instr_valid;

  logic              w_full;
  logic              w_in_load;
  logic              w_beat;
  logic              w_word_wr;
  logic              w_overflow_beat;
  logic [1:0]        w_idx_after;
  logic              w_partial_done;

  // The count MSB is set only when every word has been written (count == DEPTH).
  assign w_full    = r_count[ADDR_W];
  assign w_in_load = (r_state == S_LOAD);

  // Beats only take effect in a normal LOAD cycle. A reset or a fresh ld_start in the
  // same cycle discards the beat.
  assign w_beat          = reset_n && !ld_start && w_in_load && !w_full && ld_valid;
  assign w_word_wr       = w_beat && (r_byte_idx == 2'd3);
  assign w_overflow_beat = reset_n && !ld_start && w_in_load && w_full && ld_valid;

  // If a beat and ld_done arrive together, the beat is counted first. The partial
  // check therefore looks at the index after this cycle's beat.
  assign w_idx_after    = w_beat ? (r_byte_idx + 2'd1) : r_byte_idx;
  assign w_partial_done = w_in_load && ld_done && (w_idx_after != 2'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded handshake outputs. ld_start overrides ld_done.
  always_comb begin
    w_state_nxt = r_state;
    cpu_hold    = 1'b1;
    ld_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_hold = 1'b1;
      end
      S_LOAD: begin
        cpu_hold = 1'b1;
        ld_ready = !w_full;
        if (ld_done) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cpu_hold = 1'b0;
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
    if (ld_start) begin
      w_state_nxt = S_LOAD;
    end
  end

  // Loader bookkeeping: byte packing, word count and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_byte_idx <= 2'd0;
      r_word_buf <= 24'h0;
      r_error    <= 1'b0;
    end else if (ld_start) begin
      r_count    <= '0;
      r_byte_idx <= 2'd0;
      r_word_buf <= 24'h0;
      r_error    <= 1'b0;
    end else if (w_in_load) begin
      if (w_beat) begin
        r_word_buf <= {r_word_buf[15:0], ld_data};
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (w_word_wr) begin
        r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (w_overflow_beat) begin
        r_error <= 1'b1;
      end
      if (w_partial_done) begin
        r_error    <= 1'b1;
        r_byte_idx <= 2'd0;
      end
    end
  end

  // RAM write port. RAM contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_word_wr) begin
      r_mem[r_count[ADDR_W-1:0]] <= {r_word_buf, ld_data};
    end
  end

  // Fetch port. The read is registered so a word written on one edge is visible to a
  // fetch issued in the next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_instr       <= r_mem[fetch_addr];
      r_instr_valid <= 1'b1;
    end else begin
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Running 16-bit wrapping sum of the bytes accepted in the current load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_checksum <= 16'h0;
    end else if (ld_start) begin
      r_checksum <= 16'h0;
    end else if (w_beat) begin
      r_checksum <= r_checksum + {8'h00, ld_data};
    end
  end

  assign ld_checksum = r_checksum;
`else
  assign ld_checksum = 16'h0000;
`endif

  assign instr_out     = r_instr;
  assign instr_valid   = r_instr_valid;
  assign ld_word_count = r_count;
  assign ld_error      = r_error;

endmodule
